// File: rtl/gf16_pkg.sv
// rtl/gf16_pkg.sv - GF(16) field constants, code sizes and constant-multiply helper
package gf16_pkg;

  localparam int SYM_W = 4;
  localparam int N     = 15;
  localparam int K     = 11;
  localparam int NSYN  = 4;

  localparam logic [4:0] GF_POLY = 5'b10011;

  typedef logic [SYM_W-1:0] sym_t;

  typedef enum logic [2:0] {
    SEQ_IDLE,
    SEQ_OUT1,
    SEQ_OUT2,
    SEQ_OUT3,
    SEQ_OUT4
  } seq_state_t;

  // Repeated multiply by alpha; with a constant p this unrolls to a pure XOR network.
  function automatic sym_t gf_mul_alpha_pow(input sym_t sym, input int p);
    sym_t r;
    r = sym;
    for (int i = 0; i < p; i++) begin
      r = {r[SYM_W-2:0], 1'b0} ^ (r[SYM_W-1] ? GF_POLY[SYM_W-1:0] : '0);
    end
    return r;
  endfunction

endpackage

// File: rtl/gf16_const_mul.sv
// rtl/gf16_const_mul.sv - combinational multiply of a GF(16) symbol by alpha^P
module gf16_const_mul
  import gf16_pkg::*;
#(
  parameter int P = 1
) (
  input  logic [SYM_W-1:0] sym,
  output logic [SYM_W-1:0] prod
);

  assign prod = gf_mul_alpha_pow(sym, P);

endmodule

// File: rtl/rs_syndrome.sv
// rtl/rs_syndrome.sv - RS(15,11) syndrome accumulators with serial S1..S4 output sequencer
module rs_syndrome
  import gf16_pkg::*;
(
  input  logic             CLK,
  input  logic             RESET,
  input  logic [SYM_W-1:0] IN_SERIAL,
  input  logic [NSYN-1:0]  CONTROL,
  output logic [SYM_W-1:0] OUT_SERIAL
);

  sym_t       acc     [NSYN];
  sym_t       acc_mul [NSYN];
  sym_t       syn_q   [1:NSYN-1];
  sym_t       out_q;
  sym_t       out_next;
  seq_state_t state_q;
  seq_state_t next_state;
  logic       capture;

  assign capture    = (CONTROL == '0);
  assign OUT_SERIAL = out_q;

  for (genvar g = 0; g < NSYN; g++) begin : g_mul
    gf16_const_mul #(.P(g + 1)) u_mul (
      .sym  (acc[g]),
      .prod (acc_mul[g])
    );
  end

  // acc[j] evaluates the received polynomial at alpha^(j+1) by Horner's rule.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      for (int j = 0; j < NSYN; j++) acc[j] <= '0;
    end else begin
      for (int j = 0; j < NSYN; j++) begin
        acc[j] <= CONTROL[j] ? (acc_mul[j] ^ IN_SERIAL) : IN_SERIAL;
      end
    end
  end

  // S1 goes straight to out_q on capture; S2..S4 wait here for their slot.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      for (int j = 1; j < NSYN; j++) syn_q[j] <= '0;
    end else if (capture) begin
      for (int j = 1; j < NSYN; j++) syn_q[j] <= acc[j];
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q <= SEQ_IDLE;
      out_q   <= '0;
    end else begin
      state_q <= next_state;
      out_q   <= out_next;
    end
  end

  always_comb begin
    next_state = state_q;
    out_next   = '0;
    if (capture) begin
      next_state = SEQ_OUT1;
      out_next   = acc[0];
    end else begin
      case (state_q)
        SEQ_OUT1: begin
          next_state = SEQ_OUT2;
          out_next   = syn_q[1];
        end
        SEQ_OUT2: begin
          next_state = SEQ_OUT3;
          out_next   = syn_q[2];
        end
        SEQ_OUT3: begin
          next_state = SEQ_OUT4;
          out_next   = syn_q[3];
        end
        default: next_state = SEQ_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rs_syndrome.sv
// tb/tb_rs_syndrome.sv - scoreboard bench for rs_syndrome
module tb_rs_syndrome;

  typedef logic [3:0] frame_t [15];

  logic       CLK;
  logic       RESET;
  logic [3:0] IN_SERIAL;
  logic [3:0] CONTROL;
  logic [3:0] OUT_SERIAL;

  int checks   = 0;
  int failures = 0;

  logic [3:0] exp_q [$];
  logic [3:0] cur   [$];

  rs_syndrome dut (
    .CLK        (CLK),
    .RESET      (RESET),
    .IN_SERIAL  (IN_SERIAL),
    .CONTROL    (CONTROL),
    .OUT_SERIAL (OUT_SERIAL)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic logic [3:0] gf_mul(input logic [3:0] a, input logic [3:0] b);
    logic [3:0] p;
    logic [4:0] aa;
    p  = 4'h0;
    aa = {1'b0, a};
    for (int i = 0; i < 4; i++) begin
      if (b[i]) p = p ^ aa[3:0];
      aa = aa << 1;
      if (aa[4]) aa = aa ^ 5'b10011;
    end
    return p;
  endfunction

  function automatic logic [3:0] alpha_pow(input int e);
    logic [3:0] r;
    r = 4'h1;
    for (int i = 0; i < (e % 15); i++) r = gf_mul(r, 4'h2);
    return r;
  endfunction

  // Direct polynomial evaluation of the symbols received since the last restart.
  function automatic logic [3:0] eval_syn(input int j);
    logic [3:0] s;
    int len;
    s   = 4'h0;
    len = cur.size();
    for (int i = 0; i < len; i++) s = s ^ gf_mul(cur[i], alpha_pow(j * (len - 1 - i)));
    return s;
  endfunction

  task automatic check(input logic [3:0] exp, input string tag);
    checks++;
    assert (OUT_SERIAL === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, OUT_SERIAL, exp);
    end
  endtask

  task automatic step(input logic [3:0] sym, input logic [3:0] ctrl, input string tag);
    logic [3:0] exp;
    IN_SERIAL = sym;
    CONTROL   = ctrl;
    @(posedge CLK);
    #1;
    if (ctrl == 4'h0) begin
      exp_q.delete();
      for (int j = 1; j <= 4; j++) exp_q.push_back(eval_syn(j));
      cur.delete();
    end
    cur.push_back(sym);
    exp = (exp_q.size() > 0) ? exp_q.pop_front() : 4'h0;
    check(exp, tag);
  endtask

  task automatic send_frame(input frame_t f, input string name);
    step(f[0], 4'h0, $sformatf("%s_r14", name));
    for (int i = 1; i < 15; i++) step(f[i], 4'hF, $sformatf("%s_r%0d", name, 14 - i));
  endtask

  frame_t f_zero, f_r14, f_r0, f_spec, f_rand;

  initial begin
    f_zero = '{default: 4'h0};
    f_r14  = '{default: 4'h0};
    f_r14[0] = 4'h1;
    f_r0   = '{default: 4'h0};
    f_r0[14] = 4'h1;
    f_spec = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'hB, 4'h7, 4'h8,
               4'h9, 4'hA, 4'hB, 4'h3, 4'h1, 4'hC, 4'hC};
    for (int i = 0; i < 15; i++) f_rand[i] = 4'($urandom_range(15));

    RESET     = 1'b0;
    IN_SERIAL = 4'h0;
    CONTROL   = 4'h0;
    repeat (2) @(posedge CLK);
    #1;
    check(4'h0, "reset_out");
    @(negedge CLK);
    RESET = 1'b1;

    // Each frame's r14 capture emits the syndromes of the frame before it.
    send_frame(f_zero, "zero");
    send_frame(f_r14,  "after_zero");
    send_frame(f_r0,   "after_r14");
    send_frame(f_spec, "after_r0");
    send_frame(f_spec, "after_spec1");
    send_frame(f_rand, "after_spec2");

    step(4'h3, 4'h0, "trunc_cap1_s1");
    step(4'h5, 4'hF, "trunc_cap1_s2");
    step(4'h7, 4'h0, "trunc_cap2_s1");
    step(4'h6, 4'hF, "trunc_cap2_s2");
    step(4'h2, 4'hF, "trunc_cap2_s3");
    step(4'h1, 4'hF, "trunc_cap2_s4");
    for (int i = 0; i < 3; i++) step(4'hE, 4'hF, $sformatf("trunc_idle%0d", i));

    step(4'h9, 4'h0, "pre_reset_s1");
    step(4'h4, 4'hF, "pre_reset_s2");

    RESET = 1'b0;
    #1;
    check(4'h0, "async_reset_out");
    exp_q.delete();
    cur.delete();
    @(negedge CLK);
    RESET = 1'b1;

    step(4'hA, 4'h0, "post_reset_s1");
    for (int i = 0; i < 4; i++) step(4'h0, 4'hF, $sformatf("post_reset_%0d", i));
    step(4'h0, 4'h0, "post_reset_cap_s1");
    for (int i = 0; i < 4; i++) step(4'h0, 4'hF, $sformatf("post_reset_cap_%0d", i));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
